// File: rtl/bus_irqctl.sv
// Bus-attached interrupt controller feeding the picorv32 irq input.
// Synchronizes sources, latches level/edge pending bits, masks them and drives irq.
module bus_irqctl #(
  parameter logic [31:0] BUS_ADDR = 32'h0300_0010,
  parameter int NSRC = 8,
  parameter int IRQ_BASE = 3,
  parameter int SYNC = 1,
  localparam int BUS_IN_WIDTH = 72,
  localparam int BUS_OUT_WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic [BUS_IN_WIDTH-1:0]  bus_in,
  output logic [BUS_OUT_WIDTH-1:0] bus_out,
  input  logic [NSRC-1:0]          src,
  output logic [31:0]              irq
);

  localparam int BUS_FIELD_ADDR    = 0;
  localparam int BUS_FIELD_WDATA   = 32;
  localparam int BUS_FIELD_BE      = 64;
  localparam int BUS_FIELD_RD_REQ  = 68;
  localparam int BUS_FIELD_WR_REQ  = 69;
  localparam int BUS_FIELD_RESET_L = 70;
  localparam int BUS_FIELD_CLK     = 71;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_EDGE    = 2'd2;
  localparam logic [1:0] REG_FORCE   = 2'd3;

  logic [31:0]     addr_s;
  logic [31:0]     wdata_s;
  logic [3:0]      be_s;
  logic            rd_req_s;
  logic            wr_req_s;
  logic            hit_s;
  logic            rd_s;
  logic            wr_s;
  logic [1:0]      sel_s;
  logic [31:0]     wmask_s;
  logic [NSRC-1:0] wval_s;
  logic [NSRC-1:0] wmsk_s;
  logic            unused_s;

  logic [NSRC-1:0] s_s;
  logic [NSRC-1:0] s_d_r;
  logic [NSRC-1:0] rise_s;
  logic [NSRC-1:0] pending_r;
  logic [NSRC-1:0] enable_r;
  logic [NSRC-1:0] edge_r;
  logic [NSRC-1:0] w1c_s;
  logic [NSRC-1:0] force_s;
  logic [NSRC-1:0] pending_nx_s;
  logic [NSRC-1:0] enable_nx_s;
  logic [NSRC-1:0] edge_nx_s;
  logic [31:0]     rdata_nx_s;
  logic [31:0]     irq_nx_s;
  logic [31:0]     rdata_r;
  logic            rd_ack_r;
  logic            wr_ack_r;
  logic [31:0]     irq_r;

  assign addr_s   = bus_in[BUS_FIELD_ADDR +: 32];
  assign wdata_s  = bus_in[BUS_FIELD_WDATA +: 32];
  assign be_s     = bus_in[BUS_FIELD_BE +: 4];
  assign rd_req_s = bus_in[BUS_FIELD_RD_REQ];
  assign wr_req_s = bus_in[BUS_FIELD_WR_REQ];
  // clk/reset copies on the bus are the same nets as the dedicated ports
  assign unused_s = ^{bus_in[BUS_FIELD_CLK], bus_in[BUS_FIELD_RESET_L],
                      addr_s[1:0], wdata_s, wmask_s};

  assign hit_s = (addr_s[31:4] == BUS_ADDR[31:4]);
  assign wr_s  = wr_req_s & hit_s;
  assign rd_s  = rd_req_s & hit_s & ~wr_req_s;
  assign sel_s = addr_s[3:2];

  assign wmask_s = {{8{be_s[3]}}, {8{be_s[2]}}, {8{be_s[1]}}, {8{be_s[0]}}};
  assign wval_s  = wdata_s[NSRC-1:0] & wmask_s[NSRC-1:0];
  assign wmsk_s  = wmask_s[NSRC-1:0];

  generate
    if (SYNC != 0) begin : g_sync
      logic [NSRC-1:0] sync1_r;
      logic [NSRC-1:0] sync2_r;
      // Two-flop synchronizer for asynchronous sources.
      always_ff @(posedge clk) begin
        if (!reset_l) begin
          sync1_r <= {NSRC{1'b0}};
          sync2_r <= {NSRC{1'b0}};
        end else begin
          sync1_r <= src;
          sync2_r <= sync1_r;
        end
      end
      assign s_s = sync2_r;
    end else begin : g_nosync
      assign s_s = src;
    end
  endgenerate

  assign rise_s = s_s & ~s_d_r;

  // Next-state for registers, pending bits, read data and irq.
  always_comb begin
    w1c_s       = {NSRC{1'b0}};
    force_s     = {NSRC{1'b0}};
    enable_nx_s = enable_r;
    edge_nx_s   = edge_r;
    rdata_nx_s  = 32'h0000_0000;
    irq_nx_s    = 32'h0000_0000;

    if (wr_s) begin
      case (sel_s)
        REG_PENDING: w1c_s = wval_s;
        REG_ENABLE:  enable_nx_s = (enable_r & ~wmsk_s) | wval_s;
        REG_EDGE:    edge_nx_s = (edge_r & ~wmsk_s) | wval_s;
        REG_FORCE:   force_s = wval_s;
        default:     w1c_s = {NSRC{1'b0}};
      endcase
    end else begin
      w1c_s = {NSRC{1'b0}};
    end

    // set terms are ORed after the clear so a same-edge rise/force wins
    for (int i = 0; i < NSRC; i++) begin
      if (edge_r[i]) begin
        pending_nx_s[i] = (pending_r[i] & ~w1c_s[i]) | rise_s[i] | force_s[i];
      end else begin
        pending_nx_s[i] = s_s[i];
      end
    end

    case (sel_s)
      REG_PENDING: rdata_nx_s = {{(32-NSRC){1'b0}}, pending_r};
      REG_ENABLE:  rdata_nx_s = {{(32-NSRC){1'b0}}, enable_r};
      REG_EDGE:    rdata_nx_s = {{(32-NSRC){1'b0}}, edge_r};
      REG_FORCE:   rdata_nx_s = 32'h0000_0000;
      default:     rdata_nx_s = 32'h0000_0000;
    endcase

    for (int i = 0; i < NSRC; i++) begin
      irq_nx_s[IRQ_BASE+i] = pending_r[i] & enable_r[i];
    end
  end

  // Source history, control registers, pending state, bus response and irq.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      s_d_r     <= {NSRC{1'b0}};
      pending_r <= {NSRC{1'b0}};
      enable_r  <= {NSRC{1'b0}};
      edge_r    <= {NSRC{1'b0}};
      rdata_r   <= 32'h0000_0000;
      rd_ack_r  <= 1'b0;
      wr_ack_r  <= 1'b0;
      irq_r     <= 32'h0000_0000;
    end else begin
      s_d_r     <= s_s;
      pending_r <= pending_nx_s;
      enable_r  <= enable_nx_s;
      edge_r    <= edge_nx_s;
      rdata_r   <= rd_s ? rdata_nx_s : 32'h0000_0000;
      rd_ack_r  <= rd_s;
      wr_ack_r  <= wr_s;
      irq_r     <= irq_nx_s;
    end
  end

  assign bus_out = {wr_ack_r, rd_ack_r, rdata_r};
  assign irq     = irq_r;

endmodule

// File: tb/tb_bus_irqctl.sv
// Directed-vector bench for bus_irqctl (SYNC=1, NSRC=8, IRQ_BASE=3).
module tb_bus_irqctl;

  localparam logic [31:0] BUS_ADDR = 32'h0300_0010;

  logic        clk;
  logic        reset_l;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  be_r;
  logic        rd_req_r;
  logic        wr_req_r;
  logic [71:0] bus_in_s;
  logic [33:0] bus_out_s;
  logic [7:0]  src_r;
  logic [31:0] irq_s;
  logic [31:0] rd_data_r;

  int checks_r;
  int errors_r;

  assign bus_in_s = {clk, reset_l, wr_req_r, rd_req_r, be_r, wdata_r, addr_r};

  bus_irqctl #(
    .BUS_ADDR(BUS_ADDR),
    .NSRC(8),
    .IRQ_BASE(3),
    .SYNC(1)
  ) dut (
    .clk(clk),
    .reset_l(reset_l),
    .bus_in(bus_in_s),
    .bus_out(bus_out_s),
    .src(src_r),
    .irq(irq_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle.
  task automatic bus_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
    addr_r   = BUS_ADDR + off;
    wdata_r  = d;
    be_r     = be;
    wr_req_r = 1'b1;
    @(negedge clk);
    wr_req_r = 1'b0;
    be_r     = 4'b0000;
    check_val("wr_ack", {62'd0, bus_out_s[33:32]}, 64'd2);
  endtask

  // Called at a negedge; checks one-cycle ack, returns one cycle after the ack.
  task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
    addr_r   = BUS_ADDR + off;
    rd_req_r = 1'b1;
    @(negedge clk);
    rd_req_r = 1'b0;
    check_val("rd_ack", {62'd0, bus_out_s[33:32]}, 64'd1);
    d = bus_out_s[31:0];
    @(negedge clk);
    check_val("rd_ack_drop", {30'd0, bus_out_s}, 64'd0);
  endtask

  initial begin
    checks_r = 0;
    errors_r = 0;
    reset_l  = 1'b0;
    addr_r   = 32'h0000_0000;
    wdata_r  = 32'h0000_0000;
    be_r     = 4'b0000;
    rd_req_r = 1'b0;
    wr_req_r = 1'b0;
    src_r    = 8'hFF;

    // Reset with sources high and a request that must be ignored
    for (int i = 0; i < 4; i++) begin
      addr_r   = BUS_ADDR;
      rd_req_r = (i == 1);
      @(negedge clk);
      check_val("rst_irq", {32'd0, irq_s}, 64'd0);
      check_val("rst_bus_out", {30'd0, bus_out_s}, 64'd0);
    end
    rd_req_r = 1'b0;
    reset_l  = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(32'h0, rd_data_r);
    check_val("rst_pending_level", {32'd0, rd_data_r}, 64'h0000_00FF);
    check_val("rst_irq_masked", {32'd0, irq_s}, 64'd0);
    src_r = 8'h00;
    repeat (4) @(negedge clk);

    // Edge latch, latency, then W1C
    bus_write(32'h8, 32'h0000_0001, 4'b1111);
    bus_write(32'h4, 32'h0000_0001, 4'b1111);
    src_r = 8'h01;
    @(negedge clk);
    src_r = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_val("edge_irq_k2", {32'd0, irq_s}, 64'd0);
    @(negedge clk);
    check_val("edge_irq_k3", {32'd0, irq_s}, 64'h0000_0008);
    repeat (3) @(negedge clk);
    check_val("edge_irq_hold", {32'd0, irq_s}, 64'h0000_0008);
    bus_write(32'h0, 32'h0000_0001, 4'b1111);
    check_val("w1c_irq_ack", {32'd0, irq_s}, 64'h0000_0008);
    @(negedge clk);
    check_val("w1c_irq_clear", {32'd0, irq_s}, 64'd0);

    // Simultaneous rise and W1C on bit 2
    bus_write(32'h8, 32'h0000_0004, 4'b1111);
    src_r = 8'h04;
    @(negedge clk);
    @(negedge clk);
    bus_write(32'h0, 32'h0000_0004, 4'b1111);
    bus_read(32'h0, rd_data_r);
    check_val("set_wins_w1c", {32'd0, rd_data_r}, 64'h0000_0004);
    bus_write(32'h0, 32'h0000_0004, 4'b1111);
    bus_read(32'h0, rd_data_r);
    check_val("w1c_no_rise", {32'd0, rd_data_r}, 64'd0);
    src_r = 8'h00;
    repeat (3) @(negedge clk);

    // Level source with mask
    bus_write(32'h8, 32'h0000_0000, 4'b1111);
    bus_write(32'h4, 32'h0000_0000, 4'b1111);
    src_r = 8'h20;
    repeat (3) @(negedge clk);
    bus_read(32'h0, rd_data_r);
    check_val("level_pending", {32'd0, rd_data_r}, 64'h0000_0020);
    check_val("level_masked", {32'd0, irq_s}, 64'd0);
    bus_write(32'h4, 32'h0000_0020, 4'b1111);
    check_val("enable_irq_ack", {32'd0, irq_s}, 64'd0);
    @(negedge clk);
    check_val("enable_irq_on", {32'd0, irq_s}, 64'h0000_0100);
    src_r = 8'h00;
    repeat (3) @(negedge clk);
    check_val("level_drop_k2", {32'd0, irq_s}, 64'h0000_0100);
    @(negedge clk);
    check_val("level_drop_k3", {32'd0, irq_s}, 64'd0);

    // FORCE and byte enables
    bus_write(32'h8, 32'h0000_00FF, 4'b1111);
    bus_write(32'h4, 32'h0000_00FF, 4'b1111);
    bus_write(32'hC, 32'h0000_0080, 4'b0001);
    @(negedge clk);
    check_val("force_irq", {32'd0, irq_s}, 64'h0000_0400);
    bus_write(32'h4, 32'h0000_0000, 4'b0010);
    bus_read(32'h4, rd_data_r);
    check_val("enable_be", {32'd0, rd_data_r}, 64'h0000_00FF);
    bus_read(32'hC, rd_data_r);
    check_val("force_reads_0", {32'd0, rd_data_r}, 64'd0);
    check_val("force_irq_hold", {32'd0, irq_s}, 64'h0000_0400);

    // Decode window and ack timing
    addr_r   = BUS_ADDR + 32'h10;
    rd_req_r = 1'b1;
    @(negedge clk);
    rd_req_r = 1'b0;
    check_val("miss_bus_out", {30'd0, bus_out_s}, 64'd0);
    @(negedge clk);
    check_val("miss_bus_out2", {30'd0, bus_out_s}, 64'd0);
    bus_read(32'h4, rd_data_r);
    check_val("enable_read", {32'd0, rd_data_r}, 64'h0000_00FF);

    // Read and write together: write wins, wr_ack only
    addr_r   = BUS_ADDR + 32'h4;
    wdata_r  = 32'h0000_000F;
    be_r     = 4'b1111;
    rd_req_r = 1'b1;
    wr_req_r = 1'b1;
    @(negedge clk);
    rd_req_r = 1'b0;
    wr_req_r = 1'b0;
    check_val("rdwr_ack", {30'd0, bus_out_s}, 64'h2_0000_0000);
    @(negedge clk);
    bus_read(32'h4, rd_data_r);
    check_val("rdwr_written", {32'd0, rd_data_r}, 64'h0000_000F);

    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule
